multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the RV32I-subset datapath. It replaces the single-cycle `control` decode with a registered state machine that steps each instruction through fetch, decode, execute, memory and write-back, and waits on ready handshakes from instruction and data memory. It generates every datapath strobe: `pcWrite`, `irWrite`, `regwrite`, `memRead`, `memWrite`, `aluSrc`, `memtoReg`, `aluOp` and the branch-select. It also keeps a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 44 ++++
 rtl/multicycle_control_if.sv | 32 +++
 rtl/mc_ctrl_decode.sv | 103 ++++++++++
 rtl/multicycle_control.sv | 51 +++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the multi-cycle RV32I-subset sequencing controller.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    src;
  } alu_ctrl_t;

  // ALU setup chosen in EX and held through MEM/WB so the address/result stays stable.
  function automatic alu_ctrl_t alu_ctrl(input logic [6:0] opcode);
    alu_ctrl_t c;
    case (opcode)
      OP_R:               c = '{op: ALU_FUNCT, src: 1'b0};
      OP_I:               c = '{op: ALU_FUNCT, src: 1'b1};
      OP_LOAD, OP_STORE:  c = '{op: ALU_ADD,   src: 1'b1};
      OP_BRANCH:          c = '{op: ALU_SUB,   src: 1'b0};
      default:            c = '{op: ALU_ADD,   src: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: opcode/flags/ready in, strobes and status out.
interface multicycle_control_if #(parameter int unsigned CNT_W = 32);
  logic [6:0]       opcode;
  logic             imemReady;
  logic             memReady;
  logic             aluZero;
  logic             pcWrite;
  logic             pcSrc;
  logic             irWrite;
  logic             regwrite;
  logic             memRead;
  logic             memWrite;
  logic             aluSrc;
  logic             memtoReg;
  logic [1:0]       aluOp;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;

  modport master (
    input  opcode, imemReady, memReady, aluZero,
    output pcWrite, pcSrc, irWrite, regwrite, memRead, memWrite,
           aluSrc, memtoReg, aluOp, illegal, halted, instret, state
  );

  modport slave (
    output opcode, imemReady, memReady, aluZero,
    input  pcWrite, pcSrc, irWrite, regwrite, memRead, memWrite,
           aluSrc, memtoReg, aluOp, illegal, halted, instret, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Purely combinational strobe and next-state decode for the multi-cycle controller.
module mc_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [6:0] opcode,
  input  logic       aluZero,
  input  logic       imemReady,
  input  logic       memReady,
  output state_t     next_state,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       irWrite,
  output logic       regwrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       aluSrc,
  output logic       memtoReg,
  output logic [1:0] aluOp,
  output logic       illegal,
  output logic       halted,
  output logic       retire
);

  alu_ctrl_t ex;

  assign ex     = alu_ctrl(opcode);
  assign retire = pcWrite & ~illegal;

  always_comb begin
    next_state = S_IF;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    irWrite    = 1'b0;
    regwrite   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    aluSrc     = 1'b0;
    memtoReg   = 1'b0;
    aluOp      = ALU_ADD;
    illegal    = 1'b0;
    halted     = 1'b0;

    case (state)
      S_IF: begin
        irWrite    = imemReady;
        next_state = imemReady ? S_ID : S_IF;
      end
      S_ID: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: next_state = S_EX;
          OP_SYSTEM:                                next_state = S_HALT;
          default: begin
            illegal = 1'b1;
            pcWrite = 1'b1;
          end
        endcase
      end
      S_EX: begin
        aluOp  = ex.op;
        aluSrc = ex.src;
        case (opcode)
          OP_R, OP_I:        next_state = S_WB;
          OP_LOAD, OP_STORE: next_state = S_MEM;
          OP_BRANCH: begin
            pcWrite = 1'b1;
            pcSrc   = aluZero;
          end
          default:           next_state = S_IF;
        endcase
      end
      S_MEM: begin
        aluOp  = ex.op;
        aluSrc = ex.src;
        case (opcode)
          OP_LOAD: begin
            memRead    = 1'b1;
            next_state = memReady ? S_WB : S_MEM;
          end
          OP_STORE: begin
            memWrite   = 1'b1;
            pcWrite    = memReady;
            next_state = memReady ? S_IF : S_MEM;
          end
          default:  next_state = S_IF;
        endcase
      end
      S_WB: begin
        aluOp    = ex.op;
        aluSrc   = ex.src;
        regwrite = 1'b1;
        pcWrite  = 1'b1;
        memtoReg = (opcode == OP_LOAD);
      end
      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_IF;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer top: state register and retired-instruction counter.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t           state_q;
  state_t           next_state;
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (bus.opcode),
    .aluZero    (bus.aluZero),
    .imemReady  (bus.imemReady),
    .memReady   (bus.memReady),
    .next_state (next_state),
    .pcWrite    (bus.pcWrite),
    .pcSrc      (bus.pcSrc),
    .irWrite    (bus.irWrite),
    .regwrite   (bus.regwrite),
    .memRead    (bus.memRead),
    .memWrite   (bus.memWrite),
    .aluSrc     (bus.aluSrc),
    .memtoReg   (bus.memtoReg),
    .aluOp      (bus.aluOp),
    .illegal    (bus.illegal),
    .halted     (bus.halted),
    .retire     (retire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      instret_q <= '0;
    end else begin
      state_q <= next_state;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction reference model.
module tb_multicycle_control;
  import rv_ctrl_pkg::*;

  localparam int unsigned CW = 4;

  logic clock = 1'b0;
  logic reset;

  multicycle_control_if #(.CNT_W(CW)) bus ();

  multicycle_control #(.CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned model_ret = 0;
  logic [59:0] trace;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] strobes();
    return {bus.pcWrite, bus.pcSrc, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite,
            bus.aluSrc, bus.memtoReg, bus.aluOp, bus.illegal, bus.halted};
  endfunction

  // Reference: cycles from first IF cycle to the pcWrite cycle with no wait states.
  function automatic int unsigned ref_latency(input logic [6:0] op);
    case (op)
      OP_R, OP_I: return 4;
      OP_LOAD:    return 5;
      OP_STORE:   return 4;
      OP_BRANCH:  return 3;
      default:    return 2;
    endcase
  endfunction

  // Reference: {aluOp, aluSrc} seen when the PC is written.
  function automatic logic [2:0] ref_alu(input logic [6:0] op);
    case (op)
      OP_R:              return 3'b100;
      OP_I:              return 3'b101;
      OP_LOAD, OP_STORE: return 3'b001;
      OP_BRANCH:         return 3'b010;
      default:           return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] pick_illegal();
    logic [6:0] v;
    do v = 7'($urandom);
    while (v inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM});
    return v;
  endfunction

  function automatic logic [6:0] pick_legal();
    case ($urandom_range(0, 4))
      0:       return OP_R;
      1:       return OP_I;
      2:       return OP_LOAD;
      3:       return OP_STORE;
      default: return OP_BRANCH;
    endcase
  endfunction

  // Entered at posedge+1 with the DUT in IF; leaves at posedge+1 after the pcWrite cycle.
  task automatic run_instr(input logic [6:0] op, input int unsigned iw, input int unsigned mw,
                           input logic zero, input string tag);
    int unsigned cyc = 0;
    int unsigned n_ir = 0, n_rw = 0, n_rd = 0, n_wr = 0, n_ill = 0;
    int unsigned mem0 = iw + 3;
    bit is_load  = (op == OP_LOAD);
    bit is_store = (op == OP_STORE);
    bit is_mem   = is_load || is_store;
    bit legal    = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
    bit done = 0;
    logic       src_pc = 1'b0, m2r_pc = 1'b0;
    logic [2:0] alu_pc = 3'b000, st0 = 3'b111;
    int unsigned exp_len;
    trace = '0;
    while (!done && cyc < 64) begin
      bus.imemReady = (cyc < iw) ? 1'b0 : (cyc == iw) ? 1'b1 : 1'($urandom);
      bus.opcode    = (cyc <= iw) ? 7'($urandom) : op;
      if (is_mem && cyc >= mem0 && cyc < mem0 + mw) bus.memReady = 1'b0;
      else if (is_mem && cyc == mem0 + mw)          bus.memReady = 1'b1;
      else                                          bus.memReady = 1'($urandom);
      bus.aluZero = (cyc == iw + 2) ? zero : 1'($urandom);
      @(negedge clock);
      if (cyc == 0) st0 = bus.state;
      trace = {trace[56:0], bus.state};
      n_ir  += 32'(bus.irWrite);
      n_rw  += 32'(bus.regwrite);
      n_rd  += 32'(bus.memRead);
      n_wr  += 32'(bus.memWrite);
      n_ill += 32'(bus.illegal);
      if (bus.pcWrite) begin
        done   = 1;
        src_pc = bus.pcSrc;
        m2r_pc = bus.memtoReg;
        alu_pc = {bus.aluOp, bus.aluSrc};
      end
      cyc++;
      @(posedge clock); #1;
    end
    if (legal) model_ret = (model_ret + 1) % (1 << CW);
    exp_len = ref_latency(op) + iw + (is_mem ? mw : 0);
    check({tag, " start"},    32'(st0), 0);
    check({tag, " latency"},  cyc, exp_len);
    check({tag, " irWrite"},  n_ir, 1);
    check({tag, " regwrite"}, n_rw, (legal && !is_store && op != OP_BRANCH) ? 1 : 0);
    check({tag, " memRead"},  n_rd, is_load ? mw + 1 : 0);
    check({tag, " memWrite"}, n_wr, is_store ? mw + 1 : 0);
    check({tag, " illegal"},  n_ill, legal ? 0 : 1);
    check({tag, " pcSrc"},    32'(src_pc), (op == OP_BRANCH) ? 32'(zero) : 0);
    check({tag, " memtoReg"}, 32'(m2r_pc), 32'(is_load));
    check({tag, " alu"},      32'(alu_pc), 32'(ref_alu(op)));
    check({tag, " instret"},  32'(bus.instret), model_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.imemReady = 1'b0;
    bus.memReady  = 1'b0;
    bus.aluZero   = 1'b0;

    repeat (2) begin
      @(negedge clock);
      check("reset strobes", 32'(strobes()), 0);
      check("reset state", 32'(bus.state), 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("idle state", 32'(bus.state), 0);
      check("idle strobes", 32'(strobes()), 0);
      check("idle instret", 32'(bus.instret), 0);
    end
    @(posedge clock); #1;

    run_instr(OP_R, 0, 0, 1'b0, "rtype");
    check("rtype trace", 32'(trace[11:0]), 32'o0124);
    run_instr(OP_LOAD, 0, 2, 1'b0, "load_wait");
    run_instr(OP_BRANCH, 0, 0, 1'b1, "br_taken");
    run_instr(OP_BRANCH, 1, 0, 1'b0, "br_not");
    run_instr(OP_STORE, 1, 1, 1'b0, "store");
    run_instr(OP_I, 2, 0, 1'b0, "itype");
    run_instr(7'b0000000, 0, 0, 1'b0, "illegal0");

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 5) == 0) ? pick_illegal() : pick_legal();
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "rand");
    end

    // Counter wrap: 15 retires reach the top value, the 16th wraps to zero.
    reset = 1'b1;
    model_ret = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++)
      run_instr(pick_legal(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), "wrapfill");
    check("wrap at max", 32'(bus.instret), 15);
    run_instr(OP_R, 0, 0, 1'b0, "wrap");
    check("wrap to zero", 32'(bus.instret), 0);

    // Reset during a stalled store must drop memWrite without waiting for a clock.
    bus.imemReady = 1'b1;
    bus.opcode    = 7'($urandom);
    @(posedge clock); #1;
    bus.opcode   = OP_STORE;
    bus.memReady = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("midmem memWrite", 32'(bus.memWrite), 1);
    check("midmem state", 32'(bus.state), 3);
    reset = 1'b1;
    #1;
    check("midmem reset memWrite", 32'(bus.memWrite), 0);
    check("midmem reset state", 32'(bus.state), 0);
    model_ret = 0;
    bus.imemReady = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // SYSTEM opcode halts; only reset leaves.
    bus.imemReady = 1'b1;
    @(posedge clock); #1;
    bus.opcode = OP_SYSTEM;
    @(negedge clock);
    check("sys id strobes", 32'(strobes()), 0);
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      bus.imemReady = 1'($urandom);
      bus.memReady  = 1'($urandom);
      bus.aluZero   = 1'($urandom);
      bus.opcode    = 7'($urandom);
      @(negedge clock);
      check("halt halted", 32'(bus.halted), 1);
      check("halt strobes", 32'(strobes() & 12'hFFE), 0);
      check("halt state", 32'(bus.state), 5);
      @(posedge clock); #1;
    end
    check("halt instret", 32'(bus.instret), 0);
    reset = 1'b1;
    #1;
    check("halt exit state", 32'(bus.state), 0);
    check("halt exit halted", 32'(bus.halted), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
